branch_predictor: RTL and testbench

// - Parametrised direct-mapped branch predictor (BHT + BTB) for the five-stage pipeline.
// - IF looks up the PC combinationally and gets a predicted next-PC. EXE feeds back resolved branches.
// - Resolved branches train the tables. The block flags mispredicts and supplies the redirect PC.
// - Replaces the fixed predict-not-taken, flush-on-taken scheme of the current pipeline.

---
 rtl/branch_predictor_pkg.sv | 38 +++
 rtl/branch_predictor_if.sv | 36 +++
 rtl/branch_predictor_sat_counter.sv | 24 ++
 rtl/branch_predictor.sv | 101 ++++++++++
 tb/tb_branch_predictor.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the direct-mapped branch predictor: 2-bit counter
// encodings and the counter training helpers.
package bp_pkg;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  // Training of an existing entry: jumps pin to strong-taken, branches saturate.
  function automatic logic [1:0] ctr_next(input logic [1:0] ctr,
                                          input logic       taken,
                                          input logic       is_jump);
    logic [1:0] nxt;
    if (is_jump) begin
      nxt = CTR_ST;
    end else if (taken) begin
      nxt = (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
    end else begin
      nxt = (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
    end
    return nxt;
  endfunction

  function automatic logic [1:0] ctr_alloc(input logic taken,
                                           input logic is_jump);
    logic [1:0] nxt;
    if (is_jump) begin
      nxt = CTR_ST;
    end else if (taken) begin
      nxt = CTR_WT;
    end else begin
      nxt = CTR_WNT;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch-lookup, execute-feedback and statistics signals between the pipeline
// and the branch predictor.
interface branch_predictor_if #(
  parameter int XLEN   = 32,
  parameter int STAT_W = 16
);
  logic [XLEN-1:0]   if_pc;
  logic              pred_hit;
  logic              pred_taken;
  logic [XLEN-1:0]   pred_target;
  logic              upd_valid;
  logic              upd_is_jump;
  logic [XLEN-1:0]   upd_pc;
  logic              upd_taken;
  logic [XLEN-1:0]   upd_target;
  logic              upd_pred_taken;
  logic [XLEN-1:0]   upd_pred_target;
  logic              mispredict;
  logic [XLEN-1:0]   redirect_pc;
  logic [STAT_W-1:0] stat_branches;
  logic [STAT_W-1:0] stat_mispred;

  modport master (
    output if_pc, upd_valid, upd_is_jump, upd_pc, upd_taken, upd_target,
           upd_pred_taken, upd_pred_target,
    input  pred_hit, pred_taken, pred_target, mispredict, redirect_pc,
           stat_branches, stat_mispred
  );

  modport slave (
    input  if_pc, upd_valid, upd_is_jump, upd_pc, upd_taken, upd_target,
           upd_pred_taken, upd_pred_target,
    output pred_hit, pred_taken, pred_target, mispredict, redirect_pc,
           stat_branches, stat_mispred
  );
endinterface

// File: rtl/branch_predictor_sat_counter.sv
// Saturating up-counter with asynchronous active-low clear; holds at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  // Count qualifying edges, never wrapping past all-ones.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + {{(W-1){1'b0}}, 1'b1};
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BHT+BTB: zero-latency fetch lookup, training from resolved
// branches, mispredict detection, redirect PC and saturating statistics.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 8,
  parameter int STAT_W  = 16
) (
  input logic                i_clk,
  input logic                i_rst_n,
  branch_predictor_if.slave  bus
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(32'd4);

  logic [ENTRIES-1:0] r_valid;
  logic [1:0]         r_ctr    [ENTRIES];
  logic [TAG_W-1:0]   r_tag    [ENTRIES];
  logic [XLEN-1:0]    r_target [ENTRIES];

  logic [IDX_W-1:0]   w_if_idx;
  logic [TAG_W-1:0]   w_if_tag;
  logic               w_if_hit;
  logic [XLEN-1:0]    w_if_pc4;
  logic [IDX_W-1:0]   w_upd_idx;
  logic [TAG_W-1:0]   w_upd_tag;
  logic               w_upd_hit;
  logic               w_mispredict;

  assign w_if_idx  = bus.if_pc[IDX_W+1:2];
  assign w_if_tag  = bus.if_pc[IDX_W+2 +: TAG_W];
  assign w_upd_idx = bus.upd_pc[IDX_W+1:2];
  assign w_upd_tag = bus.upd_pc[IDX_W+2 +: TAG_W];
  assign w_if_pc4  = bus.if_pc + PC_STEP;

  // Lookup reads the pre-edge table contents; no bypass from the update port.
  assign w_if_hit        = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
  assign bus.pred_hit    = w_if_hit;
  assign bus.pred_taken  = w_if_hit && r_ctr[w_if_idx][1];
  assign bus.pred_target = (w_if_hit && r_ctr[w_if_idx][1]) ? r_target[w_if_idx] : w_if_pc4;

  assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);

  assign w_mispredict = bus.upd_valid &&
                        ((bus.upd_taken != bus.upd_pred_taken) ||
                         (bus.upd_taken && (bus.upd_target != bus.upd_pred_target)));
  assign bus.mispredict  = w_mispredict;
  assign bus.redirect_pc = bus.upd_taken ? bus.upd_target : (bus.upd_pc + PC_STEP);

  // Valid bits are the only table state that needs clearing.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= '0;
    end else if (bus.upd_valid) begin
      r_valid[w_upd_idx] <= 1'b1;
    end
  end

  // Counter/tag/target training; a miss reallocates the whole entry.
  always_ff @(posedge i_clk) begin
    if (bus.upd_valid) begin
      if (w_upd_hit) begin
        r_ctr[w_upd_idx] <= ctr_next(r_ctr[w_upd_idx], bus.upd_taken, bus.upd_is_jump);
        if (bus.upd_taken) begin
          r_target[w_upd_idx] <= bus.upd_target;
        end
      end else begin
        r_ctr[w_upd_idx]    <= ctr_alloc(bus.upd_taken, bus.upd_is_jump);
        r_tag[w_upd_idx]    <= w_upd_tag;
        r_target[w_upd_idx] <= bus.upd_target;
      end
    end
  end

  sat_counter #(.W(STAT_W)) u_stat_branches (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (bus.upd_valid),
    .o_count (bus.stat_branches)
  );

  sat_counter #(.W(STAT_W)) u_stat_mispred (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (w_mispredict),
    .o_count (bus.stat_mispred)
  );

  // Low PC bits never participate; upper bits only when the tag does not reach them.
  logic w_unused;
  if (IDX_W + 2 + TAG_W < XLEN) begin : g_unused_hi
    assign w_unused = ^{bus.if_pc[1:0], bus.upd_pc[1:0],
                        bus.if_pc[XLEN-1:IDX_W+2+TAG_W], bus.upd_pc[XLEN-1:IDX_W+2+TAG_W]};
  end else begin : g_unused_lo
    assign w_unused = ^{bus.if_pc[1:0], bus.upd_pc[1:0]};
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (ENTRIES=16, TAG_W=8, STAT_W=4).
module tb_branch_predictor;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  branch_predictor_if #(.XLEN(32), .STAT_W(4)) bp_if ();

  branch_predictor #(.XLEN(32), .ENTRIES(16), .TAG_W(8), .STAT_W(4)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bp_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                     input logic ptaken, input logic [31:0] ptgt, input logic jump);
    bp_if.upd_valid       = 1'b1;
    bp_if.upd_pc          = pc;
    bp_if.upd_taken       = taken;
    bp_if.upd_target      = tgt;
    bp_if.upd_pred_taken  = ptaken;
    bp_if.upd_pred_target = ptgt;
    bp_if.upd_is_jump     = jump;
    #1;
  endtask

  task automatic lookup(input string tag, input logic [31:0] pc, input logic hit,
                        input logic taken, input logic [31:0] tgt);
    bp_if.if_pc = pc;
    #1;
    chk({tag, "_hit"},    {31'd0, bp_if.pred_hit},   {31'd0, hit});
    chk({tag, "_taken"},  {31'd0, bp_if.pred_taken}, {31'd0, taken});
    chk({tag, "_target"}, bp_if.pred_target,         tgt);
  endtask

  task automatic stats(input string tag, input logic [3:0] br, input logic [3:0] mp);
    chk({tag, "_branches"}, {28'd0, bp_if.stat_branches}, {28'd0, br});
    chk({tag, "_mispred"},  {28'd0, bp_if.stat_mispred},  {28'd0, mp});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bp_if.if_pc           = 32'h40;
    bp_if.upd_valid       = 1'b0;
    bp_if.upd_is_jump     = 1'b0;
    bp_if.upd_pc          = 32'h0;
    bp_if.upd_taken       = 1'b0;
    bp_if.upd_target      = 32'h0;
    bp_if.upd_pred_taken  = 1'b0;
    bp_if.upd_pred_target = 32'h0;
    #12;
    lookup("reset", 32'h40, 1'b0, 1'b0, 32'h44);
    stats("reset", 4'd0, 4'd0);
    rst_n = 1'b1;
    tick();

    // Idle update port: redirect still driven, no mispredict; PC+4 wrap.
    lookup("wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);
    bp_if.upd_pc = 32'hFFFF_FFFC;
    bp_if.upd_taken = 1'b0;
    #1;
    chk("idle_redirect_wrap", bp_if.redirect_pc, 32'h0);
    bp_if.upd_taken = 1'b1;
    bp_if.upd_target = 32'h200;
    #1;
    chk("idle_mispredict", {31'd0, bp_if.mispredict}, 32'd0);
    chk("idle_redirect_taken", bp_if.redirect_pc, 32'h200);
    tick();
    stats("idle", 4'd0, 4'd0);

    // First taken branch at 0x40: allocate weak-taken.
    upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h44, 1'b0);
    chk("alloc_mispredict", {31'd0, bp_if.mispredict}, 32'd1);
    chk("alloc_redirect", bp_if.redirect_pc, 32'h100);
    lookup("alloc_same_cycle", 32'h40, 1'b0, 1'b0, 32'h44);
    tick();
    bp_if.upd_valid = 1'b0;
    lookup("alloc_next", 32'h40, 1'b1, 1'b1, 32'h100);
    stats("alloc", 4'd1, 4'd1);

    // Two not-taken updates: 10 -> 01 -> 00.
    upd(32'h40, 1'b0, 32'h0, 1'b1, 32'h100, 1'b0);
    chk("nt1_mispredict", {31'd0, bp_if.mispredict}, 32'd1);
    chk("nt1_redirect", bp_if.redirect_pc, 32'h44);
    tick();
    lookup("nt1", 32'h40, 1'b1, 1'b0, 32'h44);
    upd(32'h40, 1'b0, 32'h0, 1'b0, 32'h44, 1'b0);
    chk("nt2_mispredict", {31'd0, bp_if.mispredict}, 32'd0);
    tick();
    bp_if.upd_valid = 1'b0;
    lookup("nt2", 32'h40, 1'b1, 1'b0, 32'h44);
    stats("nt2", 4'd3, 4'd2);

    // Alias: 0x80 shares index 0 with 0x40 but carries tag 2 instead of 1.
    lookup("alias_miss", 32'h80, 1'b0, 1'b0, 32'h84);
    upd(32'h80, 1'b1, 32'h300, 1'b0, 32'h84, 1'b0);
    tick();
    bp_if.upd_valid = 1'b0;
    lookup("alias_old_evicted", 32'h40, 1'b0, 1'b0, 32'h44);
    lookup("alias_new", 32'h80, 1'b1, 1'b1, 32'h300);
    stats("alias", 4'd4, 4'd3);

    // Same-cycle jump update: lookup sees the old target, new one next cycle.
    upd(32'h80, 1'b1, 32'h400, 1'b1, 32'h300, 1'b1);
    chk("jump_target_mispredict", {31'd0, bp_if.mispredict}, 32'd1);
    lookup("jump_same_cycle", 32'h80, 1'b1, 1'b1, 32'h300);
    tick();
    bp_if.upd_valid = 1'b0;
    lookup("jump_next", 32'h80, 1'b1, 1'b1, 32'h400);

    // Strong-taken from the jump survives one not-taken; target is kept.
    upd(32'h80, 1'b0, 32'h999, 1'b1, 32'h400, 1'b0);
    tick();
    bp_if.upd_valid = 1'b0;
    lookup("jump_ctr_st", 32'h80, 1'b1, 1'b1, 32'h400);
    stats("jump", 4'd6, 4'd5);

    // Saturation: 20 mispredicting updates at 0x44 (index 1).
    for (int i = 0; i < 20; i++) begin
      upd(32'h44, 1'b1, 32'h500, 1'b0, 32'h48, 1'b0);
      tick();
    end
    bp_if.upd_valid = 1'b0;
    #1;
    stats("saturate", 4'd15, 4'd15);
    lookup("pre_reset", 32'h80, 1'b1, 1'b1, 32'h400);

    // Asynchronous reset mid-cycle: effect visible without a clock edge.
    #1;
    rst_n = 1'b0;
    #1;
    lookup("async_reset", 32'h80, 1'b0, 1'b0, 32'h84);
    stats("async_reset", 4'd0, 4'd0);
    rst_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
